// File: rtl/au_pkg.sv
// Shared definitions for the fixed-point arithmetic unit: op codes, FSM
// state codes and the saturation limits used by every result path.
package au_pkg;

    typedef logic [1:0] au_op_t;
    typedef logic [1:0] au_state_t;

    localparam au_op_t OP_ADD = 2'b00;
    localparam au_op_t OP_SUB = 2'b01;
    localparam au_op_t OP_MUL = 2'b10;
    localparam au_op_t OP_DIV = 2'b11;

    localparam au_state_t ST_IDLE    = 2'b00;
    localparam au_state_t ST_DIV_RUN = 2'b01;
    localparam au_state_t ST_DIV_FIN = 2'b10;

    // Largest / smallest two's-complement value of a w-bit word (w <= 32).
    function automatic logic signed [63:0] sat_max(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/fxp_div_core.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per
// clock, NUM_W iterations after load.
module fxp_div_core #(
    parameter int unsigned NUM_W = 24,
    parameter int unsigned DEN_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [NUM_W-1:0] dividend_i,
    input  logic [DEN_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             last_o,
    output logic             valid_o,
    output logic [NUM_W-1:0] quotient_o
);

    localparam int unsigned CNT_W = $clog2(NUM_W + 1);

    logic [DEN_W-1:0] rem_q, rem_d;
    logic [NUM_W-1:0] quo_q, quo_d;
    logic [DEN_W-1:0] den_q;
    logic [CNT_W-1:0] cnt_q;
    logic             valid_q;

    logic [DEN_W:0]   trial;
    logic [DEN_W-1:0] diff;
    logic             ge;

    // NOTE: every variable gets a value on every path through always_comb, so no latch is inferred.
    always_comb begin
        trial = {rem_q, quo_q[NUM_W-1]};
        ge    = (trial >= {1'b0, den_q});
        // Only taken when trial >= den, where the low DEN_W bits hold the exact difference.
        diff  = trial[DEN_W-1:0] - den_q;
        rem_d = ge ? diff : trial[DEN_W-1:0];
        quo_d = {quo_q[NUM_W-2:0], ge};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q   <= '0;
            quo_q   <= '0;
            den_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            rem_q   <= '0;
            quo_q   <= dividend_i;
            den_q   <= divisor_i;
            cnt_q   <= CNT_W'(NUM_W);
            valid_q <= 1'b0;
        end else if (cnt_q != '0) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                valid_q <= 1'b1;
            end
        end
    end

    assign busy_o     = (cnt_q != '0);
    assign last_o     = (cnt_q == CNT_W'(1));
    assign valid_o    = valid_q;
    assign quotient_o = quo_q;

endmodule

// File: rtl/fxp_arith_unit.sv
// Signed Q(WIDTH-FRAC).FRAC arithmetic unit: single-cycle saturating
// ADD/SUB/MUL and a multi-cycle DIV, with sticky done/flag outputs.
module fxp_arith_unit
    import au_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic [WIDTH-1:0] result_o,
    output logic             done_o,
    output logic             busy_o,
    output logic             ovf_o,
    output logic             div0_o
);

    localparam int unsigned NUM_W = WIDTH + FRAC;
    localparam int unsigned DEN_W = WIDTH + 1;
    localparam logic signed [63:0] SAT_MAX = sat_max(WIDTH);
    localparam logic signed [63:0] SAT_MIN = sat_min(WIDTH);

    // Returns {ovf, clamped value}.
    function automatic logic [WIDTH:0] saturate(input logic signed [63:0] v);
        if (v > SAT_MAX) begin
            return {1'b1, SAT_MAX[WIDTH-1:0]};
        end else if (v < SAT_MIN) begin
            return {1'b1, SAT_MIN[WIDTH-1:0]};
        end
        return {1'b0, v[WIDTH-1:0]};
    endfunction

    au_state_t        state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             div0_q, div0_d;
    logic             quo_neg_q, quo_neg_d;
    logic             a_neg_q, a_neg_d;
    logic             by_zero_q, by_zero_d;

    logic signed [WIDTH-1:0]   a_s, b_s;
    logic signed [WIDTH:0]     a_ext, b_ext, a_abs, b_abs;
    logic signed [2*WIDTH-1:0] a_w, b_w, prod, prod_sh;
    logic signed [63:0]        div_mag;
    logic [WIDTH:0]            add_sat, sub_sat, mul_sat, div_sat;

    logic             div_load;
    logic             div_busy, div_last, div_valid;
    logic [NUM_W-1:0] div_dividend, div_quo;
    logic [DEN_W-1:0] div_divisor;

    assign a_s   = opa_i;
    assign b_s   = opb_i;
    assign a_ext = (WIDTH + 1)'(a_s);
    assign b_ext = (WIDTH + 1)'(b_s);
    // One extra bit keeps |most negative| representable.
    assign a_abs = a_ext[WIDTH] ? -a_ext : a_ext;
    assign b_abs = b_ext[WIDTH] ? -b_ext : b_ext;

    assign a_w     = (2 * WIDTH)'(a_s);
    assign b_w     = (2 * WIDTH)'(b_s);
    assign prod    = a_w * b_w;
    assign prod_sh = prod >>> FRAC;

    assign add_sat = saturate(64'(a_ext + b_ext));
    assign sub_sat = saturate(64'(a_ext - b_ext));
    assign mul_sat = saturate(64'(prod_sh));

    assign div_dividend = NUM_W'(unsigned'(a_abs)) << FRAC;
    assign div_divisor  = unsigned'(b_abs);
    assign div_mag      = signed'(64'(div_quo));
    assign div_sat      = saturate(quo_neg_q ? -div_mag : div_mag);

    fxp_div_core #(
        .NUM_W (NUM_W),
        .DEN_W (DEN_W)
    ) u_div_core (
        .clk        (clk),
        .rst        (rst),
        .load_i     (div_load),
        .dividend_i (div_dividend),
        .divisor_i  (div_divisor),
        .busy_o     (div_busy),
        .last_o     (div_last),
        .valid_o    (div_valid),
        .quotient_o (div_quo)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
        div0_d    = div0_q;
        quo_neg_d = quo_neg_q;
        a_neg_d   = a_neg_q;
        by_zero_d = by_zero_q;
        div_load  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    done_d = 1'b1;
                    ovf_d  = 1'b0;
                    div0_d = 1'b0;
                    unique case (op_i)
                        OP_ADD: {ovf_d, result_d} = add_sat;
                        OP_SUB: {ovf_d, result_d} = sub_sat;
                        OP_MUL: {ovf_d, result_d} = mul_sat;
                        default: begin
                            done_d    = 1'b0;
                            quo_neg_d = a_s[WIDTH-1] ^ b_s[WIDTH-1];
                            a_neg_d   = a_s[WIDTH-1];
                            by_zero_d = (opb_i == '0);
                            if (opb_i == '0) begin
                                state_d = ST_DIV_FIN;
                            end else begin
                                div_load = 1'b1;
                                state_d  = ST_DIV_RUN;
                            end
                        end
                    endcase
                end
            end
            ST_DIV_RUN: begin
                // Leave on the edge that retires the final quotient bit.
                if (div_last || !div_busy) begin
                    state_d = ST_DIV_FIN;
                end
            end
            ST_DIV_FIN: begin
                if (by_zero_q) begin
                    result_d = a_neg_q ? SAT_MIN[WIDTH-1:0] : SAT_MAX[WIDTH-1:0];
                    ovf_d    = 1'b1;
                    div0_d   = 1'b1;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else if (div_valid) begin
                    {ovf_d, result_d} = div_sat;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            div0_q    <= 1'b0;
            quo_neg_q <= 1'b0;
            a_neg_q   <= 1'b0;
            by_zero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            div0_q    <= div0_d;
            quo_neg_q <= quo_neg_d;
            a_neg_q   <= a_neg_d;
            by_zero_q <= by_zero_d;
        end
    end

    assign result_o = result_q;
    assign done_o   = done_q;
    assign busy_o   = (state_q != ST_IDLE);
    assign ovf_o    = ovf_q;
    assign div0_o   = div0_q;

endmodule

// File: tb/tb_fxp_arith_unit.sv
// Self-checking bench for fxp_arith_unit: directed cases plus random traffic
// compared every cycle against a timeline model built on integer arithmetic.
module tb_fxp_arith_unit;

    localparam int W = 16;
    localparam int F = 8;
    localparam longint MAXV = (64'sd1 <<< (W - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (W - 1));

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [1:0]   op_i;
    logic [W-1:0] opa_i, opb_i;
    logic [W-1:0] result_o;
    logic         done_o, busy_o, ovf_o, div0_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: visible outputs plus one pending completion.
    logic [W-1:0] m_result;
    logic         m_done, m_busy, m_ovf, m_div0;
    int           m_remain;
    logic [W-1:0] p_result;
    logic         p_ovf, p_div0;

    fxp_arith_unit #(.WIDTH(W), .FRAC(F)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .op_i     (op_i),
        .opa_i    (opa_i),
        .opb_i    (opb_i),
        .result_o (result_o),
        .done_o   (done_o),
        .busy_o   (busy_o),
        .ovf_o    (ovf_o),
        .div0_o   (div0_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic void reference(input logic [1:0] op, input logic [W-1:0] a_raw,
                                      input logic [W-1:0] b_raw, output logic [W-1:0] res,
                                      output logic ovf, output logic div0, output int lat);
        longint a = longint'(signed'(a_raw));
        longint b = longint'(signed'(b_raw));
        longint v;
        div0 = 1'b0;
        lat  = 1;
        ovf  = 1'b0;
        case (op)
            2'd0: v = a + b;
            2'd1: v = a - b;
            2'd2: v = (a * b) >>> F;
            default: begin
                lat = W + F + 2;
                if (b == 0) begin
                    lat  = 2;
                    div0 = 1'b1;
                    ovf  = 1'b1;
                    v    = (a >= 0) ? MAXV : MINV;
                end else begin
                    v = (a * (64'sd1 <<< F)) / b;
                end
            end
        endcase
        if (v > MAXV) begin
            v = MAXV; ovf = 1'b1;
        end else if (v < MINV) begin
            v = MINV; ovf = 1'b1;
        end
        res = v[W-1:0];
    endfunction

    task automatic model_edge();
        logic [W-1:0] r;
        logic         o, d;
        int           lat;
        if (rst) begin
            m_result = '0; m_done = 0; m_busy = 0; m_ovf = 0; m_div0 = 0; m_remain = 0;
        end else if (m_remain > 0) begin
            m_remain--;
            if (m_remain == 0) begin
                m_result = p_result; m_ovf = p_ovf; m_div0 = p_div0;
                m_done = 1'b1; m_busy = 1'b0;
            end
        end else if (start_i) begin
            reference(op_i, opa_i, opb_i, r, o, d, lat);
            if (lat == 1) begin
                m_result = r; m_ovf = o; m_div0 = d; m_done = 1'b1;
            end else begin
                m_done = 0; m_ovf = 0; m_div0 = 0; m_busy = 1'b1;
                m_remain = lat - 1;
                p_result = r; p_ovf = o; p_div0 = d;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("cycle", {result_o, done_o, busy_o, ovf_o, div0_o},
              {m_result, m_done, m_busy, m_ovf, m_div0});
    endtask

    task automatic drive(input logic s, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic r = 1'b0);
        rst = r; start_i = s; op_i = op; opa_i = a; opb_i = b;
        step();
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, '0, '0);
    endtask

    // Cycles from the start step until done_o is seen, bounded.
    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc = 1;
        busy_cnt = int'(busy_o);
        while (!done_o && cyc < 100) begin
            idle();
            cyc++;
            busy_cnt += int'(busy_o);
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 16'h8000;
            2: return 16'h7FFF;
            3: return 16'hFFFF;
            4: return W'($urandom_range(0, 16'h03FF)) ^ ({W{1'($urandom_range(0, 1))}});
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int cyc, bc;
        m_remain = 0;
        drive(1'b0, 2'd0, '0, '0, 1'b1);
        drive(1'b0, 2'd0, '0, '0, 1'b1);
        check("reset_result", result_o, 0);
        check("reset_flags", {done_o, busy_o, ovf_o, div0_o}, 4'b0000);

        drive(1'b1, 2'd0, 16'h0180, 16'h0240);
        check("add_result", result_o, 16'h03C0);
        check("add_flags", {done_o, ovf_o}, 2'b10);
        drive(1'b1, 2'd1, 16'h0180, 16'h0240);
        check("sub_result", result_o, 16'hFF40);
        drive(1'b1, 2'd2, 16'h0180, 16'h0240);
        check("mul_result", result_o, 16'h0360);
        drive(1'b1, 2'd2, 16'h7F00, 16'h0200);
        check("mul_sat_result", result_o, 16'h7FFF);
        check("mul_sat_ovf", ovf_o, 1'b1);

        // DIV with an ADD start pulsed mid-run, which must be ignored.
        drive(1'b1, 2'd3, 16'h0240, 16'h0180);
        cyc = 1;
        bc  = int'(busy_o);
        while (!done_o && cyc < 100) begin
            if (cyc == 4) drive(1'b1, 2'd0, 16'h1111, 16'h2222);
            else idle();
            cyc++;
            bc += int'(busy_o);
        end
        check("div_latency", cyc, 26);
        check("div_busy_cycles", bc, 25);
        check("div_result", result_o, 16'h0180);

        drive(1'b1, 2'd3, 16'h8000, 16'h0100);
        wait_done(cyc, bc);
        check("div_min_result", result_o, 16'h8000);
        check("div_min_ovf", ovf_o, 1'b0);

        drive(1'b1, 2'd3, 16'hFE00, 16'h0000);
        wait_done(cyc, bc);
        check("div0_latency", cyc, 2);
        check("div0_result", result_o, 16'h8000);
        check("div0_flags", {div0_o, ovf_o, done_o}, 3'b111);

        for (int i = 0; i < 10; i++) begin
            idle();
            check("done_sticky", {done_o, result_o}, {1'b1, 16'h8000});
        end
        drive(1'b1, 2'd3, 16'h0100, 16'h0100);
        check("done_clears", {done_o, div0_o, ovf_o}, 3'b000);
        wait_done(cyc, bc);
        check("div_one_result", result_o, 16'h0100);

        drive(1'b1, 2'd3, 16'h0240, 16'h0180);
        repeat (8) idle();
        drive(1'b0, 2'd0, '0, '0, 1'b1);
        check("rst_mid_div", {busy_o, done_o, result_o}, {2'b00, 16'h0000});
        drive(1'b1, 2'd0, 16'h0180, 16'h0240);
        check("add_after_rst", {done_o, result_o}, {1'b1, 16'h03C0});

        for (int i = 0; i < 4000; i++) begin
            drive(1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), pick(), pick(),
                  1'($urandom_range(0, 299) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
